bs_gnrtr_n_rbtr: RTL and testbench

// - Shared-bus generator and arbiter connecting `drvrs` device FIFOs on `bits` bus(es).
// - Grants one pending device at a time, pops its head packet and routes it to the

---
 rtl/bs_gnrtr_n_rbtr.sv | 119 +++++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator/arbiter: per bus, round-robin grant, pop the winner's head packet, push it to its addressed device.
// Broadcast delivery (all devices except the source) is enabled by defining BS_BROADCAST_EN.
module bs_gnrtr_n_rbtr #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0]              pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam bit BC_EN =
`ifdef BS_BROADCAST_EN
        1'b1;
`else
        1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_PUSH
    } state_t;

    for (genvar gi = 0; gi < bits; gi++) begin : g_bus
        state_t             state_q, state_d;
        logic [GW-1:0]      grant_q, grant_d;
        logic [GW-1:0]      last_q, last_d;
        logic [pckg_sz-1:0] pkt_q, pkt_d;
        logic [7:0]         addr;
        logic               addr_is_bc;
        logic               rr_hit;
        logic [GW-1:0]      rr_idx;
        logic [drvrs-1:0]   pop_b, push_b;

        assign addr       = pkt_q[pckg_sz-1 -: 8];
        assign addr_is_bc = (addr == broadcast);

        // Scan from farthest to nearest so the first pending index after last_q wins.
        always_comb begin
            int idx;
            idx    = 0;
            rr_hit = 1'b0;
            rr_idx = last_q;
            for (int k = drvrs; k >= 1; k--) begin
                idx = (int'(last_q) + k) % drvrs;
                if (pndng[gi][idx]) begin
                    rr_hit = 1'b1;
                    rr_idx = GW'(idx);
                end
            end
        end

        always_comb begin
            state_d = state_q;
            grant_d = grant_q;
            last_d  = last_q;
            pkt_d   = pkt_q;
            case (state_q)
                ST_IDLE: begin
                    if (rr_hit) begin
                        grant_d = rr_idx;
                        state_d = ST_POP;
                    end
                end
                ST_POP: begin
                    pkt_d   = D_pop[gi][grant_q];
                    last_d  = grant_q;
                    state_d = ST_PUSH;
                end
                ST_PUSH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                grant_q <= '0;
                last_q  <= GW'(drvrs - 1);
                pkt_q   <= '0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                last_q  <= last_d;
                pkt_q   <= pkt_d;
            end
        end

        // Strobes decode only registered state, so an async reset clears them at once.
        always_comb begin
            pop_b  = '0;
            push_b = '0;
            for (int i = 0; i < drvrs; i++) begin
                pop_b[i]  = (state_q == ST_POP) && (grant_q == GW'(i));
                push_b[i] = (state_q == ST_PUSH) &&
                            (addr_is_bc ? (BC_EN && (grant_q != GW'(i)))
                                        : (addr == 8'(i)));
            end
        end

        assign pop[gi]    = pop_b;
        assign push[gi]   = push_b;
        assign D_push[gi] = {drvrs{pkt_q}};
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Randomized bench for bs_gnrtr_n_rbtr: device FIFO model, transaction-level round-robin reference, scoreboard monitor.
module tb_bs_gnrtr_n_rbtr;

    localparam int ND = 4;

    localparam bit BC_EN =
`ifdef BS_BROADCAST_EN
        1'b1;
`else
        1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [0:0][ND-1:0]        pndng;
    logic [0:0][ND-1:0]        push;
    logic [0:0][ND-1:0]        pop;
    logic [0:0][ND-1:0][15:0]  D_pop;
    logic [0:0][ND-1:0][15:0]  D_push;

    bs_gnrtr_n_rbtr dut (
        .clk    (clk),
        .reset  (rst_n),
        .pndng  (pndng),
        .push   (push),
        .pop    (pop),
        .D_pop  (D_pop),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  mask;
        bit          first;
    } exp_t;

    logic [15:0] dev_q [ND][$];
    exp_t        exp_q [$];
    bit          en;
    bit          mon_en;
    logic [3:0]  pop_prev;
    int          model_last;
    int          tests;
    int          fails;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Destination set derived from the address byte.
    function automatic logic [3:0] dest_mask(input int src, input logic [15:0] pkt);
        int a;
        a = int'(pkt[15:8]);
        if (a == 255) return BC_EN ? (4'hF & ~(4'b1 << src)) : 4'h0;
        if (a < ND) return 4'b1 << a;
        return 4'h0;
    endfunction

    // Reference: drain a snapshot of all queues in round-robin order.
    task automatic build_expect();
        logic [15:0] mq [ND][$];
        bit first;
        bit any;
        int idx;
        exp_t e;
        for (int i = 0; i < ND; i++) mq[i] = dev_q[i];
        first = 1'b1;
        forever begin
            any = 1'b0;
            for (int i = 0; i < ND; i++) if (mq[i].size() != 0) any = 1'b1;
            if (!any) break;
            idx = 0;
            for (int k = 1; k <= ND; k++) begin
                idx = (model_last + k) % ND;
                if (mq[idx].size() != 0) break;
            end
            e.src   = idx;
            e.pkt   = mq[idx].pop_front();
            e.mask  = dest_mask(idx, e.pkt);
            e.first = first;
            exp_q.push_back(e);
            first      = 1'b0;
            model_last = idx;
        end
    endtask

    // Device FIFO model: first-word-fall-through, head removed after the pop cycle.
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++)
            if (pop_prev[i] && dev_q[i].size() > 0) void'(dev_q[i].pop_front());
        pop_prev = pop[0];
        for (int i = 0; i < ND; i++) begin
            pndng[0][i] = en && (dev_q[i].size() > 0);
            D_pop[0][i] = (dev_q[i].size() > 0) ? dev_q[i][0] : 16'h0;
        end
    end

    // Monitor / scoreboard.
    bit          expect_push;
    bit          have_cur;
    exp_t        cur;
    int          last_pop_cyc;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            expect_push = 1'b0;
            have_cur    = 1'b0;
        end else begin
            if (pop[0] != 0 && push[0] != 0) chk("pop_push_overlap", {28'h0, pop[0] & push[0]}, 32'h0);
            if (pop[0] != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {28'h0, pop[0]}, 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("pop_src", {28'h0, pop[0]}, 32'(4'b1 << cur.src));
                    if (!cur.first) chk("pop_spacing", 32'(cyc - last_pop_cyc), 32'd3);
                    last_pop_cyc = cyc;
                    expect_push  = 1'b1;
                    have_cur     = 1'b1;
                end
            end else if (expect_push) begin
                chk("push_mask", {28'h0, push[0]}, {28'h0, cur.mask});
                chk("d_push", {16'h0, D_push[0][int'(cyc) % ND]}, {16'h0, cur.pkt});
                $display("[TB] txn src=%0d pkt=%h push=%b", cur.src, cur.pkt, push[0]);
                expect_push = 1'b0;
            end else begin
                if (push[0] != 0) chk("idle_push", {28'h0, push[0]}, 32'h0);
                if (have_cur && D_push[0][0] !== cur.pkt) chk("d_push_hold", {16'h0, D_push[0][0]}, {16'h0, cur.pkt});
            end
        end
    end

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && !expect_push) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({name, "_timeout"}, 32'(exp_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        en = 1'b0;
    endtask

    task automatic run_burst(input string name);
        en = 1'b0;
        build_expect();
        en = 1'b1;
        wait_drain(name);
    endtask

    function automatic logic [15:0] rand_pkt();
        logic [7:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = 8'($urandom_range(0, ND - 1));
            3:       a = 8'hFF;
            default: a = 8'($urandom_range(4, 254));
        endcase
        return {a, 8'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        tests = 0; fails = 0; cyc = 0;
        en = 1'b0; mon_en = 1'b0; pop_prev = '0;
        pndng = '0; D_pop = '0;
        model_last = ND - 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_pop", {28'h0, pop[0]}, 32'h0);
        chk("reset_push", {28'h0, push[0]}, 32'h0);
        chk("reset_dpush", {16'h0, D_push[0][0]}, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        dev_q[1].push_back(16'h02AB);
        run_burst("unicast");
        dev_q[0].push_back(16'hFF55);
        run_burst("broadcast");
        for (int i = 0; i < ND; i++)
            for (int n = 0; n < 2; n++) dev_q[i].push_back({8'((i + 1) % ND), 8'(16 * i + n)});
        run_burst("all_pending");
        dev_q[3].push_back(16'h0711);
        run_burst("bad_addr");

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < ND; i++)
                for (int n = int'($urandom_range(0, 3)); n > 0; n--) dev_q[i].push_back(rand_pkt());
            run_burst("random");
        end

        // Reset during PUSH: strobes drop asynchronously.
        mon_en = 1'b0;
        dev_q[0].push_back(16'h0122);
        en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (push[0] != 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reset_test_push_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_push", {28'h0, push[0]}, 32'h0);
        chk("async_reset_pop", {28'h0, pop[0]}, 32'h0);
        chk("async_reset_dpush", {16'h0, D_push[0][0]}, 32'h0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < ND; i++) dev_q[i].delete();
        exp_q.delete();
        dev_q[2].push_back(16'h0033);
        dev_q[0].push_back(16'h0344);
        model_last = ND - 1;
        build_expect();
        mon_en = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        en = 1'b1;
        wait_drain("after_reset");

        // Quiet bus: monitor flags any strobe.
        en = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("quiet_pop", {28'h0, pop[0]}, 32'h0);
        chk("quiet_push", {28'h0, push[0]}, 32'h0);
        en = 1'b0;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
